tc_frame_capture: RTL

//  Read-side consumer of the pre-trigger delay FIFO (packed {x0,x0z} pairs, 2*BIT_WIDTH bits).
//  - Waits for the FIFO's "delay line primed" flag, then arms.
//  - On a trigger rising edge, captures FRAME_PAIRS consecutive delayed pairs.
//  - Outputs each pair as two sign-extended 16-bit samples, tagged with frame start/end.
//  - Sits between the delay FIFO and the accumulation/readout path.

---
 rtl/tc_frame_capture_pkg.sv | 14 +
 rtl/tc_pair_unpack.sv | 21 ++
 rtl/tc_frame_capture.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tc_frame_capture_pkg.sv
// Shared definitions for the trigger-capture path: FSM state encodings and the
// common sample width used by the capture block and downstream accumulators.
package tc_frame_capture_pkg;

    localparam int unsigned TC_SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } tc_state_t;

endpackage

// File: rtl/tc_pair_unpack.sv
// Splits a packed {x0, x0z} pair and sign-extends both samples to TC_SAMPLE_W.
module tc_pair_unpack
    import tc_frame_capture_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 14
) (
    input  logic [2*BIT_WIDTH-1:0]   i_pair,
    output logic [TC_SAMPLE_W-1:0]   o_x0,
    output logic [TC_SAMPLE_W-1:0]   o_x0z
);

    logic [BIT_WIDTH-1:0] w_x0;
    logic [BIT_WIDTH-1:0] w_x0z;

    assign w_x0  = i_pair[2*BIT_WIDTH-1:BIT_WIDTH];
    assign w_x0z = i_pair[BIT_WIDTH-1:0];

    assign o_x0  = {{(TC_SAMPLE_W-BIT_WIDTH){w_x0[BIT_WIDTH-1]}},  w_x0};
    assign o_x0z = {{(TC_SAMPLE_W-BIT_WIDTH){w_x0z[BIT_WIDTH-1]}}, w_x0z};

endmodule

// File: rtl/tc_frame_capture.sv
// Trigger-driven frame grabber on the read side of the pre-trigger delay FIFO:
// arms once the delay line is primed, then emits FRAME_PAIRS sign-extended pairs per trigger edge.
module tc_frame_capture
    import tc_frame_capture_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 14,
    parameter int unsigned FRAME_PAIRS = 1000,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*BIT_WIDTH-1:0]  tc_data_i,
    input  logic                    tc_ready_i,
    input  logic                    trig_i,
    input  logic                    enable_i,
    output logic [TC_SAMPLE_W-1:0]  x0_o,
    output logic [TC_SAMPLE_W-1:0]  x0z_o,
    output logic                    data_valid_o,
    output logic                    frame_start_o,
    output logic                    frame_end_o,
    output logic                    busy_o,
    output logic                    trig_lost_o,
    output logic [CNT_W-1:0]        frame_cnt_o
);

    localparam int unsigned PAIR_W = $clog2(FRAME_PAIRS);
    localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(FRAME_PAIRS - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLDOFF - 1);

    tc_state_t r_state;
    tc_state_t w_next_state;

    logic                   r_trig_d;
    logic                   w_trig_edge;
    logic [PAIR_W-1:0]      r_pair_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   w_take;
    logic                   w_first;
    logic                   w_last;
    logic                   w_lost_set;
    logic [TC_SAMPLE_W-1:0] w_x0;
    logic [TC_SAMPLE_W-1:0] w_x0z;

    logic [TC_SAMPLE_W-1:0] r_x0;
    logic [TC_SAMPLE_W-1:0] r_x0z;
    logic                   r_valid;
    logic                   r_start;
    logic                   r_end;
    logic                   r_lost;
    logic [CNT_W-1:0]       r_frame_cnt;

    tc_pair_unpack #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_unpack (
        .i_pair (tc_data_i),
        .o_x0   (w_x0),
        .o_x0z  (w_x0z)
    );

    assign w_trig_edge = trig_i & ~r_trig_d;
    assign w_lost_set  = w_trig_edge && (r_state != ST_ARMED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pair 0 is taken in the ARMED edge cycle itself, so CAPTURE starts at pair 1.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_first      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tc_ready_i && enable_i) begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!tc_ready_i || !enable_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_trig_edge) begin
                    w_take       = 1'b1;
                    w_first      = 1'b1;
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!tc_ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_take = 1'b1;
                    if (r_pair_cnt == LAST_PAIR) begin
                        w_last       = 1'b1;
                        w_next_state = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (r_hold_cnt == LAST_HOLD) begin
                    w_next_state = (tc_ready_i && enable_i) ? ST_ARMED : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_d    <= 1'b0;
            r_pair_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_x0        <= '0;
            r_x0z       <= '0;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_lost      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_trig_d <= trig_i;
            r_valid  <= w_take;
            r_start  <= w_first;
            r_end    <= w_last;

            if (w_take) begin
                r_x0  <= w_x0;
                r_x0z <= w_x0z;
            end

            if (w_first) begin
                r_pair_cnt <= PAIR_W'(1);
            end else if (w_take) begin
                r_pair_cnt <= r_pair_cnt + PAIR_W'(1);
            end

            if (r_state == ST_HOLDOFF) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_last) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end

            if (!enable_i) begin
                r_lost <= 1'b0;
            end else if (w_lost_set) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign x0_o          = r_x0;
    assign x0z_o         = r_x0z;
    assign data_valid_o  = r_valid;
    assign frame_start_o = r_start;
    assign frame_end_o   = r_end;
    assign busy_o        = (r_state == ST_CAPTURE) || (r_state == ST_HOLDOFF);
    assign trig_lost_o   = r_lost;
    assign frame_cnt_o   = r_frame_cnt;

endmodule
